macc_job_scheduler: RTL and testbench
=====================================

MACC_JOB_SCHEDULER -- requirements
Module: macc_job_scheduler

Interface
REQ-001 Parameter KEY_W, 4, width of the working_key driven to the MAC.
REQ-002 Parameter TIMEOUT, 64, watchdog limit in cycles from job issue to mac_done (>=2).
REQ-003 Ports, listed as name, direction, width, meaning:
- ap_clk, in, 1, sole clock; all logic on its rising edge.
- ap_rst_n, in, 1, synchronous active-low reset.
- key_load, in, 1, qualifies key_bit.
- key_bit, in, 1, serial key bit, MSB first.
- key_valid, out, 1, full key loaded.
- working_key, out, KEY_W, key to the MAC.
- req_start, in, 2, per-requester job request pulse.
- req_grant, out, 2, one-cycle grant pulse.
- req_done, out, 2, one-cycle completion pulse.
- req_err, out, 2, one-cycle timeout pulse.
- mac_sel, out, 1, operand/result mux select, the granted requester index.
- mac_start, out, 1, to MAC ap_start.
- mac_ready, in, 1, from MAC ap_ready.
- mac_done, in, 1, from MAC ap_done.
- busy, out, 1, high in any state other than S_NOKEY or S_IDLE.
- err_cnt, out, 8, saturating timeout count.

Function
REQ-004 States: S_NOKEY, S_IDLE, S_ISSUE, S_WAIT, S_DONE.
REQ-005 S_NOKEY: each key_load cycle shifts key_bit into working_key LSB; on the KEY_W-th bit the block sets key_valid=1 next cycle and enters S_IDLE.
REQ-006 key_load in S_IDLE clears key_valid, resets the bit count, counts that cycle's bit as bit 1 and enters S_NOKEY; key_load in S_ISSUE, S_WAIT or S_DONE is ignored.
REQ-007 req_start[i] sets pending[i] in any state, including S_NOKEY; a pulse while pending[i]=1 is dropped (queue depth 1 per requester).
REQ-008 S_IDLE with a pending bit: round-robin selection; when both are pending, the requester other than last_grant wins.
REQ-009 The grant cycle pulses req_grant[i], registers mac_sel=i, updates last_grant=i and enters S_ISSUE.
REQ-010 S_ISSUE: mac_start=1 is held until the cycle mac_ready=1.
- mac_ready=1 with mac_done=0: enter S_WAIT.
- mac_ready=1 with mac_done=1 in the same cycle: enter S_DONE.
REQ-011 mac_start is 0 in every state except S_ISSUE.
REQ-012 The watchdog clears on entry to S_ISSUE and increments every cycle in S_ISSUE and S_WAIT.
REQ-013 S_WAIT: mac_done=1 enters S_DONE.
REQ-014 Timeout: the watchdog equals TIMEOUT-1 without mac_done. Action on that cycle:
- pulse req_err[mac_sel] next cycle;
- clear pending[mac_sel];
- increment err_cnt, saturating at 255;
- clear key_valid and working_key, because a wrong key leaves the MAC FSM looping;
- enter S_NOKEY.
If mac_done and the timeout occur in the same cycle, mac_done wins.
REQ-015 S_DONE: pulses req_done[mac_sel] for one cycle, clears pending[mac_sel] and returns to S_IDLE. A req_start[mac_sel] in the same cycle re-sets pending (set wins over clear).
REQ-016 mac_sel is stable from grant until S_DONE or the timeout exit.
REQ-017 Grant-to-issue latency is 1 cycle. Done-to-req_done latency is 1 cycle.
REQ-018 At most one bit of req_grant, req_done and req_err is high per cycle.

Reset
REQ-019 With ap_rst_n=0 at an edge, the block enters S_NOKEY and sets:
- outputs key_valid, working_key, req_grant, req_done, req_err, mac_start, busy, err_cnt and mac_sel to 0;
- internal pending=0, last_grant=1, watchdog=0, key bit count=0.
REQ-020 Reset mid-job aborts silently: no req_done or req_err pulse, and a rekey is required.

Verification
REQ-021 Reset, then 4 key_load cycles with bits 1,0,1,0 -> key_valid=1 on the following cycle and working_key=4'b1010.
REQ-022 Both req_start pulsed together after the key is loaded -> req_grant=2'b01 first. With mac_ready and mac_done returned 3 cycles after issue, req_done=2'b01, then req_grant=2'b10 two cycles after that done.
REQ-023 mac_ready held low for 5 cycles -> mac_start stays high for exactly those cycles plus the accept cycle, and mac_sel stays unchanged throughout.
REQ-024 mac_done never asserted with TIMEOUT=64 -> req_err pulses 64 cycles after issue, err_cnt=1, key_valid=0, and a pending request is not granted until a rekey.
REQ-025 req_start[0] pulsed during S_NOKEY and again while pending -> exactly one job after the key loads.
REQ-026 req_start[0] in the S_DONE cycle of job 0 -> a second grant to requester 0, and ap_rst_n=0 asserted mid S_WAIT -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/macc_job_scheduler.sv
// Two-requester job scheduler in front of a keyed MAC: serial key load, round-robin
// grant, start/ready handshake, done/timeout reporting and a saturating error count.
module macc_job_scheduler #(
    parameter int unsigned KEY_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             key_load,
    input  logic             key_bit,
    output logic             key_valid,
    output logic [KEY_W-1:0] working_key,
    input  logic [1:0]       req_start,
    output logic [1:0]       req_grant,
    output logic [1:0]       req_done,
    output logic [1:0]       req_err,
    output logic             mac_sel,
    output logic             mac_start,
    input  logic             mac_ready,
    input  logic             mac_done,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam int unsigned WdW  = $clog2(TIMEOUT);
    localparam int unsigned CntW = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {
        StNoKey,
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e          state;
    logic [CntW-1:0] key_cnt;
    logic [WdW-1:0]  wdog;
    logic [1:0]      pending;
    logic            last_grant;

    logic            arb_sel;
    logic [1:0]      sel_onehot;
    logic            wd_expired;
    logic            timeout_now;
    logic [1:0]      pend_clr;

    always_comb begin
        arb_sel     = 1'b0;
        sel_onehot  = mac_sel ? 2'b10 : 2'b01;
        wd_expired  = (wdog == WdW'(TIMEOUT - 1));
        timeout_now = 1'b0;
        pend_clr    = 2'b00;

        // Both pending: the requester that was not granted last time wins.
        if (pending == 2'b11) begin
            arb_sel = ~last_grant;
        end else begin
            arb_sel = pending[1];
        end

        // A completion seen on the expiry cycle takes precedence over the timeout.
        if (state == StIssue) begin
            timeout_now = wd_expired && !(mac_ready && mac_done);
        end else if (state == StWait) begin
            timeout_now = wd_expired && !mac_done;
        end

        if (state == StDone || timeout_now) begin
            pend_clr = sel_onehot;
        end
    end

    assign mac_start = (state == StIssue);
    assign busy      = (state == StIssue) || (state == StWait) || (state == StDone);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= StNoKey;
            key_cnt     <= '0;
            key_valid   <= 1'b0;
            working_key <= '0;
            wdog        <= '0;
            pending     <= 2'b00;
            last_grant  <= 1'b1;
            mac_sel     <= 1'b0;
            req_grant   <= 2'b00;
            req_done    <= 2'b00;
            req_err     <= 2'b00;
            err_cnt     <= 8'd0;
        end else begin
            req_grant <= 2'b00;
            req_done  <= 2'b00;
            req_err   <= 2'b00;
            // Set wins over clear so a request in the completion cycle is kept.
            pending   <= (pending & ~pend_clr) | req_start;

            unique case (state)
                StNoKey: begin
                    if (key_load) begin
                        working_key <= {working_key[KEY_W-2:0], key_bit};
                        if (key_cnt == CntW'(KEY_W - 1)) begin
                            key_cnt   <= '0;
                            key_valid <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            key_cnt <= key_cnt + CntW'(1);
                        end
                    end
                end
                StIdle: begin
                    if (key_load) begin
                        key_valid   <= 1'b0;
                        working_key <= {working_key[KEY_W-2:0], key_bit};
                        key_cnt     <= CntW'(1);
                        state       <= StNoKey;
                    end else if (pending != 2'b00) begin
                        req_grant  <= arb_sel ? 2'b10 : 2'b01;
                        mac_sel    <= arb_sel;
                        last_grant <= arb_sel;
                        wdog       <= '0;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    wdog <= wdog + WdW'(1);
                    if (mac_ready && mac_done) begin
                        req_done <= sel_onehot;
                        state    <= StDone;
                    end else if (mac_ready) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    wdog <= wdog + WdW'(1);
                    if (mac_done) begin
                        req_done <= sel_onehot;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StNoKey;
                end
            endcase

            // A stuck MAC usually means a bad key, so drop it and force a rekey.
            if (timeout_now) begin
                req_err     <= sel_onehot;
                key_valid   <= 1'b0;
                working_key <= '0;
                key_cnt     <= '0;
                state       <= StNoKey;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_job_scheduler.sv
// Self-checking bench for macc_job_scheduler: key-load vector table, directed job
// sequences, and a randomized run against a timestamp-based job model.
module tb_macc_job_scheduler;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             key_load = 1'b0;
    logic             key_bit = 1'b0;
    logic             key_valid;
    logic [KEY_W-1:0] working_key;
    logic [1:0]       req_start = 2'b00;
    logic [1:0]       req_grant;
    logic [1:0]       req_done;
    logic [1:0]       req_err;
    logic             mac_sel;
    logic             mac_start;
    logic             mac_ready = 1'b0;
    logic             mac_done = 1'b0;
    logic             busy;
    logic [7:0]       err_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 ap_clk = ~ap_clk;

    macc_job_scheduler #(
        .KEY_W  (KEY_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .key_load   (key_load),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .working_key(working_key),
        .req_start  (req_start),
        .req_grant  (req_grant),
        .req_done   (req_done),
        .req_err    (req_err),
        .mac_sel    (mac_sel),
        .mac_start  (mac_start),
        .mac_ready  (mac_ready),
        .mac_done   (mac_done),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic       ld;
        logic       kbit;
        logic       exp_kv;
        logic [3:0] exp_wk;
    } key_vec_t;

    key_vec_t key_tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        key_load  = 1'b0;
        req_start = 2'b00;
        mac_ready = 1'b0;
        mac_done  = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic load_key(input logic [3:0] k);
        for (int i = KEY_W - 1; i >= 0; i--) begin
            key_load = 1'b1;
            key_bit  = k[i];
            tick();
        end
        key_load = 1'b0;
        key_bit  = 1'b0;
    endtask

    function automatic logic [1:0] oh(input logic s);
        return s ? 2'b10 : 2'b01;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_kv"}, 32'(key_valid), 32'd0);
        chk({tag, "_wk"}, 32'(working_key), 32'd0);
        chk({tag, "_grant"}, 32'(req_grant), 32'd0);
        chk({tag, "_done"}, 32'(req_done), 32'd0);
        chk({tag, "_err"}, 32'(req_err), 32'd0);
        chk({tag, "_start"}, 32'(mac_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_sel"}, 32'(mac_sel), 32'd0);
    endtask

    initial begin
        int         n_hi;
        int         bad;
        logic       sel_ok;
        // random-phase model
        logic [1:0] m_pend;
        logic       m_last;
        logic       m_sel;
        logic       job;
        int         g;
        int         acc;
        int         dn;
        logic [1:0] rs;
        logic [1:0] clr;
        logic [1:0] exp_grant;
        logic [1:0] exp_done;
        logic       exp_start;
        logic       exp_busy;

        key_tbl[0] = '{1'b1, 1'b1, 1'b0, 4'b0001};
        key_tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0010};
        key_tbl[2] = '{1'b1, 1'b1, 1'b0, 4'b0101};
        key_tbl[3] = '{1'b1, 1'b0, 1'b1, 4'b1010};
        key_tbl[4] = '{1'b0, 1'b1, 1'b1, 4'b1010};
        key_tbl[5] = '{1'b1, 1'b1, 1'b0, 4'b0101};
        key_tbl[6] = '{1'b1, 1'b1, 1'b0, 4'b1011};
        key_tbl[7] = '{1'b1, 1'b0, 1'b0, 4'b0110};
        key_tbl[8] = '{1'b1, 1'b0, 1'b1, 4'b1100};
        key_tbl[9] = '{1'b0, 1'b0, 1'b1, 4'b1100};

        do_reset();
        chk_all_zero("reset");

        // Key shift-in, then a rekey from idle that restarts the bit count.
        for (int i = 0; i < 10; i++) begin
            key_load = key_tbl[i].ld;
            key_bit  = key_tbl[i].kbit;
            tick();
            chk($sformatf("key_kv_%0d", i), 32'(key_valid), 32'(key_tbl[i].exp_kv));
            chk($sformatf("key_wk_%0d", i), 32'(working_key), 32'(key_tbl[i].exp_wk));
            chk($sformatf("key_busy_%0d", i), 32'(busy), 32'd0);
        end
        key_load = 1'b0;

        // Simultaneous requests: requester 0 first, then 1.
        req_start = 2'b11;
        tick();
        req_start = 2'b00;
        tick();
        chk("rr_first_grant", 32'(req_grant), 32'b01);
        chk("issue_start", 32'(mac_start), 32'd1);
        chk("issue_sel", 32'(mac_sel), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("start_held", 32'(mac_start), 32'd1);
        end
        mac_ready = 1'b1;
        mac_done  = 1'b1;
        tick();
        mac_ready = 1'b0;
        mac_done  = 1'b0;
        chk("done0", 32'(req_done), 32'b01);
        chk("start_dropped", 32'(mac_start), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        tick();
        chk("gap_no_grant", 32'(req_grant), 32'd0);
        chk("gap_done_cleared", 32'(req_done), 32'd0);
        tick();
        chk("rr_second_grant", 32'(req_grant), 32'b10);
        chk("second_sel", 32'(mac_sel), 32'd1);

        // Slow accept: 5 cycles of mac_ready low.
        n_hi   = 0;
        sel_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (mac_start) n_hi++;
            if (mac_sel !== 1'b1) sel_ok = 1'b0;
            tick();
        end
        if (mac_start) n_hi++;
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mac_start) n_hi++;
            if (mac_sel !== 1'b1) sel_ok = 1'b0;
            tick();
        end
        chk("start_cycles", 32'(n_hi), 32'd6);
        chk("sel_stable", 32'(sel_ok), 32'd1);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("done1", 32'(req_done), 32'b10);
        chk("sel_at_done", 32'(mac_sel), 32'd1);
        tick();

        // Watchdog expiry with a second request queued behind it.
        req_start = 2'b01;
        tick();
        req_start = 2'b00;
        tick();
        chk("to_grant", 32'(req_grant), 32'b01);
        req_start = 2'b10;
        bad = 0;
        for (int k = 1; k < 64; k++) begin
            tick();
            req_start = 2'b00;
            if (req_err !== 2'b00 || req_done !== 2'b00) bad++;
        end
        tick();
        chk("to_no_early", 32'(bad), 32'd0);
        chk("to_err", 32'(req_err), 32'b01);
        chk("to_errcnt", 32'(err_cnt), 32'd1);
        chk("to_kv", 32'(key_valid), 32'd0);
        chk("to_wk", 32'(working_key), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_grant !== 2'b00 || req_err !== 2'b00) bad++;
        end
        chk("to_no_grant_nokey", 32'(bad), 32'd0);
        load_key(4'b0110);
        chk("rekey_kv", 32'(key_valid), 32'd1);
        tick();
        chk("rekey_grant", 32'(req_grant), 32'b10);
        mac_ready = 1'b1;
        mac_done  = 1'b1;
        tick();
        mac_ready = 1'b0;
        mac_done  = 1'b0;
        chk("rekey_done", 32'(req_done), 32'b10);
        chk("errcnt_kept", 32'(err_cnt), 32'd1);

        // Requests before the key, one of them redundant: exactly one job.
        do_reset();
        req_start = 2'b01;
        tick();
        req_start = 2'b01;
        tick();
        req_start = 2'b00;
        tick();
        load_key(4'b1010);
        tick();
        chk("prekey_grant", 32'(req_grant), 32'b01);
        mac_ready = 1'b1;
        mac_done  = 1'b1;
        tick();
        mac_ready = 1'b0;
        mac_done  = 1'b0;
        chk("prekey_done", 32'(req_done), 32'b01);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (req_grant !== 2'b00) bad++;
        end
        chk("prekey_single_job", 32'(bad), 32'd0);

        // Re-request in the done cycle, then reset while waiting.
        req_start = 2'b01;
        tick();
        req_start = 2'b00;
        tick();
        chk("rq_grant", 32'(req_grant), 32'b01);
        mac_ready = 1'b1;
        mac_done  = 1'b1;
        tick();
        mac_ready = 1'b0;
        mac_done  = 1'b0;
        chk("rq_done", 32'(req_done), 32'b01);
        req_start = 2'b01;
        tick();
        req_start = 2'b00;
        chk("rq_idle_gap", 32'(req_grant), 32'd0);
        tick();
        chk("rq_regrant", 32'(req_grant), 32'b01);
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        chk("rq_wait_busy", 32'(busy), 32'd1);
        chk("rq_wait_start", 32'(mac_start), 32'd0);
        ap_rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        ap_rst_n = 1'b1;
        mac_done = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            mac_done = 1'b0;
            if (req_done !== 2'b00 || req_err !== 2'b00 || key_valid !== 1'b0) bad++;
        end
        chk("midrst_silent", 32'(bad), 32'd0);

        // Randomized traffic with a bench-side MAC responder and job model.
        do_reset();
        load_key(4'b1001);
        m_pend = 2'b00;
        m_last = 1'b1;
        m_sel  = 1'b0;
        job    = 1'b0;
        g      = 0;
        acc    = 0;
        dn     = 0;
        for (int t = 0; t < 3000; t++) begin
            exp_grant = (job && t == g) ? oh(m_sel) : 2'b00;
            exp_done  = (job && t == dn + 1) ? oh(m_sel) : 2'b00;
            exp_start = job && t >= g && t <= acc;
            exp_busy  = job && t >= g && t <= dn + 1;
            chk("rnd_grant", 32'(req_grant), 32'(exp_grant));
            chk("rnd_done", 32'(req_done), 32'(exp_done));
            chk("rnd_start", 32'(mac_start), 32'(exp_start));
            chk("rnd_busy", 32'(busy), 32'(exp_busy));
            chk("rnd_err", 32'(req_err), 32'd0);
            chk("rnd_kv", 32'(key_valid), 32'd1);
            if (job) chk("rnd_sel", 32'(mac_sel), 32'(m_sel));

            rs[0]     = ($urandom_range(0, 7) == 0);
            rs[1]     = ($urandom_range(0, 7) == 0);
            req_start = rs;
            if (job && t <= dn) begin
                mac_ready = (t == acc);
                mac_done  = (t == dn);
            end else begin
                // Stray handshake noise while no job is outstanding.
                mac_ready = ($urandom_range(0, 3) == 0);
                mac_done  = ($urandom_range(0, 3) == 0);
            end

            clr = (job && t == dn + 1) ? oh(m_sel) : 2'b00;
            if (!job && m_pend != 2'b00) begin
                m_sel  = (m_pend == 2'b11) ? ~m_last : m_pend[1];
                m_last = m_sel;
                job    = 1'b1;
                g      = t + 1;
                acc    = g + int'($urandom_range(0, 4));
                dn     = acc + int'($urandom_range(0, 5));
            end else if (job && t == dn + 1) begin
                job = 1'b0;
            end
            m_pend = (m_pend & ~clr) | rs;
            tick();
        end
        req_start = 2'b00;
        mac_ready = 1'b0;
        mac_done  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
